inst_encoder: RTL and testbench
===============================

# inst_encoder

Sequential RISC-V RV32I instruction encoder: it accepts decoded instruction fields over a valid/ready stream and emits packed 32-bit instruction words, each with a sequential IMEM word address. It is the inverse of the core's instruction decoder. It sits between the on-chip program generator / UART loader path and the IMEM write port. Fields are range-checked; illegal requests are dropped and reported.

## Interface
- IMEM_AW, 14: IMEM word-address width.
- BASE_ADDR, 0: first word address after reset or flush.
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the pipeline, address and count.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_op  in  4  instruction class (enum in package).
- in_funct3  in  3  funct3 field.
- in_alt  in  1  funct7[5] (SUB/SRA/SRAI select).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate. For LUI/AUIPC this is the full value. For CSR it is the CSR address.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  IMEM side accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  IMEM_AW  word address for out_inst.
- err_valid  out  1  one-cycle pulse: a bundle was rejected.
- err_code  out  2  01 range, 10 alignment, 11 illegal op/funct3; held until the next error.
- count  out  IMEM_AW+1  words emitted; saturates at all-ones.
- wrapped  out  1  sticky; set when out_addr wraps.

## Operation
- Classes: R, I_ALU, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, CSR. Opcodes use the standard RV32I encodings.
- R: funct7 = {1'b0, in_alt, 5'b0}.
- I_ALU shifts (funct3 001/101): in_imm[31:5] must be 0. Bit 30 = in_alt, and only for 101.
- Range checks (signed fit), giving err 01 on failure:
  - I, LOAD, JALR, STORE, I_ALU non-shift: 12 bits.
  - BRANCH: 13 bits.
  - JAL: 21 bits.
  - CSR: unsigned 12 bits.
- Shape checks:
  - BRANCH and JAL require in_imm[0]=0, else err 10.
  - LUI and AUIPC require in_imm[11:0]=0, else err 10.
- Illegal funct3 gives err 11:
  - BRANCH 010/011, LOAD 011/110/111, STORE ≥011, JALR ≠000, CSR 000/100.
  - An undefined in_op also gives err 11.
- When several checks fail, the priority is 11 > 01 > 10.
- A rejected bundle produces no output word, does not advance the address and does not change count.
- Address:
  - Starts at BASE_ADDR.
  - Increments on each output handshake (out_valid & out_ready), modulo 2^IMEM_AW.
  - The increment from all-ones to 0 sets wrapped.
- Reset values: in_ready=1 (after rst deasserts), out_valid=0, out_inst=0, out_addr=BASE_ADDR, err_valid=0, err_code=0, count=0, wrapped=0.

## Timing
- Two-stage pipeline:
  - S1 registers the fields and check results.
  - S2 registers out_inst, out_addr and out_valid.
- Latency: a bundle accepted in cycle N gives out_valid in cycle N+2 when there is no backpressure. Throughput is 1 word/cycle.
- err_valid pulses in cycle N+1, as the bundle leaves S1. The S1 slot is freed in the same cycle.
- Ready chain:
  - s2_ready = !s2_valid | out_ready.
  - s1_ready = !s1_valid | s1_bad | s2_ready.
  - in_ready = s1_ready.
- out_inst and out_addr hold stable while out_valid & !out_ready.
- At most 2 bundles are in flight. With out_ready low, the third bundle sees in_ready=0.
- out_addr is the value assigned at S2 load: the address counter plus one if an output handshake completes that cycle. Consecutive words therefore get consecutive addresses.
- flush:
  - Clears S1, S2, err_valid and count; sets the address to BASE_ADDR and clears wrapped.
  - Wins over any same-cycle input or output handshake; that bundle is dropped and the word is not counted.
- rst asserted mid-stream discards in-flight words immediately (asynchronous).

## Structure
- Package inst_encoder_pkg holds:
  - The in_op enum.
  - RV32I opcode constants.
  - err_code constants.
  - Immediate-format enum (I/S/B/U/J).
- One sub-module, imm_packer: combinational packing of in_imm into instruction bit positions for each format, plus the range and alignment flags.

## Test plan
- ADDI x1,x0,5 → 0x00500093. ADD x3,x1,x2 → 0x002081B3. SUB (alt=1) → 0x402081B3. Addresses are 0,1,2.
- SW x2,8(x1) → 0x0020A423. BEQ x1,x2,+8 → 0x00208463. JAL x1,+16 → 0x010000EF. LUI x5,0x12345000 → 0x123452B7.
- ADDI imm=2048 → err_valid pulse, err_code 01, no word. The next legal bundle takes the unchanged address.
- BEQ imm=7 → err 10. BRANCH funct3=010 with imm=7 → err 11 (priority).
- Hold out_ready=0 and push 3 bundles → in_ready=0 on the third. Release → 3 words in order, consecutive addresses, count=3.
- IMEM_AW=2: emit 5 words → addresses 0,1,2,3,0 and wrapped=1. Then flush with a bundle in each stage → count=0, out_valid=0, next address BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Holds the request class enum, opcode/error constants and the immediate-format enum.
package inst_encoder_pkg;

    typedef enum logic [3:0] {
        OP_R      = 4'd0,
        OP_I_ALU  = 4'd1,
        OP_LOAD   = 4'd2,
        OP_STORE  = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LUI    = 4'd5,
        OP_AUIPC  = 4'd6,
        OP_JAL    = 4'd7,
        OP_JALR   = 4'd8,
        OP_CSR    = 4'd9
    } op_e;

    // FMT_NONE is used by register-register instructions, which carry no immediate.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    // True when value is representable as a two's-complement number of the given width.
    function automatic logic fitsSigned(input logic [31:0] value, input int bits);
        logic [31:0] w_hi;
        w_hi = $signed(value) >>> (bits - 1);
        return (w_hi == '0) || (w_hi == '1);
    endfunction

endpackage

// File: rtl/imm_packer.sv
// Places a 32-bit immediate into RV32I instruction bit positions for one format,
// flagging immediates that do not fit the format or violate its alignment.
module imm_packer
    import inst_encoder_pkg::*;
(
    input  logic [31:0] i_imm,
    input  imm_fmt_e    i_fmt,
    input  logic        i_unsigned,
    output logic [31:0] o_bits,
    output logic        o_rangeErr,
    output logic        o_alignErr
);

    always_comb begin
        o_bits     = '0;
        o_rangeErr = 1'b0;
        o_alignErr = 1'b0;
        case (i_fmt)
            FMT_I: begin
                o_bits     = {i_imm[11:0], 20'b0};
                o_rangeErr = i_unsigned ? (i_imm[31:12] != '0) : !fitsSigned(i_imm, 12);
            end
            FMT_S: begin
                o_bits     = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
                o_rangeErr = !fitsSigned(i_imm, 12);
            end
            FMT_B: begin
                o_bits     = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
                o_rangeErr = !fitsSigned(i_imm, 13);
                o_alignErr = i_imm[0];
            end
            FMT_U: begin
                o_bits     = {i_imm[31:12], 12'b0};
                o_alignErr = (i_imm[11:0] != '0);
            end
            FMT_J: begin
                o_bits     = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
                o_rangeErr = !fitsSigned(i_imm, 21);
                o_alignErr = i_imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I encoder: S1 holds checked fields, S2 holds the packed word and its
// IMEM address. Rejected bundles are reported from S1 and never reach S2.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int IMEM_AW   = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [2:0]         in_funct3,
    input  logic               in_alt,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [IMEM_AW-1:0] out_addr,
    output logic               err_valid,
    output logic [1:0]         err_code,
    output logic [IMEM_AW:0]   count,
    output logic               wrapped
);

    localparam logic [IMEM_AW-1:0] BaseAddr = IMEM_AW'(BASE_ADDR);

    op_e          w_op;
    imm_fmt_e     w_fmt;
    logic [6:0]   w_opcode;
    logic         w_illegal;
    logic         w_unsigned;
    logic         w_isShift;
    logic [31:0]  w_packBits;
    logic         w_packRange;
    logic         w_packAlign;
    logic [31:0]  w_immBits;
    logic         w_rangeErr;
    logic [1:0]   w_errCode;

    logic         r_s1Valid;
    logic         r_s1Bad;
    imm_fmt_e     r_s1Fmt;
    logic [6:0]   r_s1Opcode;
    logic [2:0]   r_s1Funct3;
    logic         r_s1Alt;
    logic [4:0]   r_s1Rd;
    logic [4:0]   r_s1Rs1;
    logic [4:0]   r_s1Rs2;
    logic [31:0]  r_s1ImmBits;
    logic [1:0]   r_errCode;

    logic               r_s2Valid;
    logic [31:0]        r_outInst;
    logic [IMEM_AW-1:0] r_outAddr;
    logic [IMEM_AW-1:0] r_addrCnt;
    logic [IMEM_AW:0]   r_count;
    logic               r_wrapped;

    logic         w_s2Ready;
    logic         w_s1Ready;
    logic         w_s2Load;
    logic         w_outFire;
    logic [31:0]  w_fields;

    imm_packer u_immPacker (
        .i_imm      (in_imm),
        .i_fmt      (w_fmt),
        .i_unsigned (w_unsigned),
        .o_bits     (w_packBits),
        .o_rangeErr (w_packRange),
        .o_alignErr (w_packAlign)
    );

    always_comb begin
        w_op       = op_e'(in_op);
        w_fmt      = FMT_NONE;
        w_opcode   = '0;
        w_illegal  = 1'b0;
        w_unsigned = 1'b0;
        w_isShift  = 1'b0;
        case (w_op)
            OP_R:      w_opcode = OPC_OP;
            OP_I_ALU: begin
                w_fmt     = FMT_I;
                w_opcode  = OPC_OP_IMM;
                w_isShift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
            end
            OP_LOAD: begin
                w_fmt     = FMT_I;
                w_opcode  = OPC_LOAD;
                w_illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
            end
            OP_STORE: begin
                w_fmt     = FMT_S;
                w_opcode  = OPC_STORE;
                w_illegal = (in_funct3 >= 3'b011);
            end
            OP_BRANCH: begin
                w_fmt     = FMT_B;
                w_opcode  = OPC_BRANCH;
                w_illegal = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
            end
            OP_LUI: begin
                w_fmt    = FMT_U;
                w_opcode = OPC_LUI;
            end
            OP_AUIPC: begin
                w_fmt    = FMT_U;
                w_opcode = OPC_AUIPC;
            end
            OP_JAL: begin
                w_fmt    = FMT_J;
                w_opcode = OPC_JAL;
            end
            OP_JALR: begin
                w_fmt     = FMT_I;
                w_opcode  = OPC_JALR;
                w_illegal = (in_funct3 != 3'b000);
            end
            OP_CSR: begin
                w_fmt      = FMT_I;
                w_opcode   = OPC_SYSTEM;
                w_unsigned = 1'b1;
                w_illegal  = (in_funct3 == 3'b000) || (in_funct3 == 3'b100);
            end
            default:   w_illegal = 1'b1;
        endcase
    end

    // Shift immediates replace the packer output: shamt in [24:20], SRA/SRAI select in bit 30.
    always_comb begin
        w_immBits  = w_packBits;
        w_rangeErr = w_packRange;
        if (w_isShift) begin
            w_immBits  = {1'b0, in_alt & (in_funct3 == 3'b101), 5'b0, in_imm[4:0], 20'b0};
            w_rangeErr = (in_imm[31:5] != '0);
        end
        if (w_illegal)
            w_errCode = ERR_ILLEGAL;
        else if (w_rangeErr)
            w_errCode = ERR_RANGE;
        else if (w_packAlign)
            w_errCode = ERR_ALIGN;
        else
            w_errCode = ERR_NONE;
    end

    assign w_s2Ready = !r_s2Valid || out_ready;
    assign w_s1Ready = !r_s1Valid || r_s1Bad || w_s2Ready;
    assign w_s2Load  = r_s1Valid && !r_s1Bad && w_s2Ready;
    assign w_outFire = r_s2Valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid   <= 1'b0;
            r_s1Bad     <= 1'b0;
            r_s1Fmt     <= FMT_NONE;
            r_s1Opcode  <= '0;
            r_s1Funct3  <= '0;
            r_s1Alt     <= 1'b0;
            r_s1Rd      <= '0;
            r_s1Rs1     <= '0;
            r_s1Rs2     <= '0;
            r_s1ImmBits <= '0;
            r_errCode   <= ERR_NONE;
        end else if (flush) begin
            r_s1Valid <= 1'b0;
            r_s1Bad   <= 1'b0;
        end else if (w_s1Ready) begin
            r_s1Valid   <= in_valid;
            r_s1Bad     <= in_valid && (w_errCode != ERR_NONE);
            r_s1Fmt     <= w_fmt;
            r_s1Opcode  <= w_opcode;
            r_s1Funct3  <= in_funct3;
            r_s1Alt     <= in_alt;
            r_s1Rd      <= in_rd;
            r_s1Rs1     <= in_rs1;
            r_s1Rs2     <= in_rs2;
            r_s1ImmBits <= w_immBits;
            if (in_valid && (w_errCode != ERR_NONE))
                r_errCode <= w_errCode;
        end
    end

    always_comb begin
        case (r_s1Fmt)
            FMT_NONE:     w_fields = {1'b0, r_s1Alt, 5'b0, r_s1Rs2, r_s1Rs1, r_s1Funct3, r_s1Rd, r_s1Opcode};
            FMT_I:        w_fields = {12'b0, r_s1Rs1, r_s1Funct3, r_s1Rd, r_s1Opcode};
            FMT_S, FMT_B: w_fields = {7'b0, r_s1Rs2, r_s1Rs1, r_s1Funct3, 5'b0, r_s1Opcode};
            default:      w_fields = {20'b0, r_s1Rd, r_s1Opcode};
        endcase
    end

    // The address counter tracks the next word to retire; a word loaded while its
    // predecessor retires takes the post-increment value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_outInst <= '0;
            r_outAddr <= BaseAddr;
            r_addrCnt <= BaseAddr;
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else if (flush) begin
            r_s2Valid <= 1'b0;
            r_addrCnt <= BaseAddr;
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else begin
            if (w_s2Ready)
                r_s2Valid <= w_s2Load;
            if (w_s2Load) begin
                r_outInst <= w_fields | r_s1ImmBits;
                r_outAddr <= r_addrCnt + IMEM_AW'(w_outFire);
            end
            if (w_outFire) begin
                r_addrCnt <= r_addrCnt + IMEM_AW'(1);
                if (r_addrCnt == '1)
                    r_wrapped <= 1'b1;
                if (r_count != '1)
                    r_count <= r_count + (IMEM_AW + 1)'(1);
            end
        end
    end

    assign in_ready  = w_s1Ready;
    assign out_valid = r_s2Valid;
    assign out_inst  = r_outInst;
    assign out_addr  = r_outAddr;
    assign err_valid = r_s1Valid && r_s1Bad;
    assign err_code  = r_errCode;
    assign count     = r_count;
    assign wrapped   = r_wrapped;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder with a 4-word IMEM so wrap and count saturation are reachable.
// Expected words/errors are queued at acceptance and retired by a monitor on output handshakes.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int AW   = 2;
    localparam int BASE = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [2:0]    in_funct3;
    logic          in_alt;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_addr;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [AW:0]   count;
    logic          wrapped;

    int checks = 0;
    int errors = 0;

    logic [31:0]   instQ[$];
    logic [1:0]    errQ[$];
    logic [AW-1:0] expAddr;
    logic [AW:0]   expCount;
    logic          expWrapped;
    logic [1:0]    lastErr;
    logic [31:0]   monInst;
    logic [1:0]    monErr;
    logic [31:0]   heldInst;
    logic [AW-1:0] heldAddr;

    inst_encoder #(.IMEM_AW(AW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .err_valid (err_valid),
        .err_code  (err_code),
        .count     (count),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic driveFields(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm);
        in_op     = op;
        in_funct3 = f3;
        in_alt    = alt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic pushExpect(input logic [31:0] expInst, input logic [1:0] expErr);
        if (expErr == ERR_NONE)
            instQ.push_back(expInst);
        else
            errQ.push_back(expErr);
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] expInst, input logic [1:0] expErr);
        int n;
        @(negedge clk);
        driveFields(op, f3, alt, rd, rs1, rs2, imm);
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checkOutput("acceptTimeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            pushExpect(expInst, expErr);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drainAll();
        int n;
        n = 0;
        while ((instQ.size() != 0 || errQ.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            checkOutput("drainTimeout", 32'(instQ.size() + errQ.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "Count"}, 32'(count), 32'(expCount));
        checkOutput({tag, "Wrapped"}, {31'b0, wrapped}, {31'b0, expWrapped});
    endtask

    // Retire expectations on handshakes and error pulses; both are void during reset/flush.
    always @(negedge clk) begin
        #2;
        if (!rst && !flush) begin
            if (out_valid && out_ready) begin
                if (instQ.size() == 0) begin
                    checkOutput("spuriousWord", out_inst, 32'hFFFF_FFFF);
                end else begin
                    monInst = instQ.pop_front();
                    checkOutput("inst", out_inst, monInst);
                    checkOutput("addr", 32'(out_addr), 32'(expAddr));
                    if (expAddr == '1)
                        expWrapped = 1'b1;
                    expAddr = expAddr + 1'b1;
                    if (expCount != '1)
                        expCount = expCount + 1'b1;
                end
            end
            if (err_valid) begin
                if (errQ.size() == 0) begin
                    checkOutput("spuriousErr", {30'b0, err_code}, 32'hFFFF_FFFF);
                end else begin
                    monErr = errQ.pop_front();
                    checkOutput("errCode", {30'b0, err_code}, {30'b0, monErr});
                    lastErr = monErr;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        driveFields(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid   = 1'b0;
        expAddr    = AW'(BASE);
        expCount   = '0;
        expWrapped = 1'b0;
        lastErr    = ERR_NONE;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
        checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstOutInst", out_inst, 32'd0);
        checkOutput("rstOutAddr", 32'(out_addr), 32'(BASE));
        checkOutput("rstErrValid", {31'b0, err_valid}, 32'd0);
        checkOutput("rstErrCode", {30'b0, err_code}, 32'd0);
        checkCounters("rst");

        // First word alone to observe the two-cycle latency.
        applyStimulus(OP_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, ERR_NONE);
        @(negedge clk);
        #1;
        checkOutput("latencyN1", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("latencyN2", {31'b0, out_valid}, 32'd1);
        applyStimulus(OP_R, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, ERR_NONE);
        applyStimulus(OP_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, ERR_NONE);
        drainAll();
        checkCounters("alu");

        applyStimulus(OP_STORE,  3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423, ERR_NONE);
        applyStimulus(OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_8463, ERR_NONE);
        applyStimulus(OP_JAL,    3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16,        32'h0100_00EF, ERR_NONE);
        applyStimulus(OP_LUI,    3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, ERR_NONE);
        drainAll();
        checkCounters("formats");

        // Rejections interleaved with legal boundary values.
        applyStimulus(OP_I_ALU,  3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'd0,         ERR_RANGE);
        applyStimulus(OP_I_ALU,  3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, ERR_NONE);
        applyStimulus(OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7,         32'd0,         ERR_ALIGN);
        applyStimulus(OP_BRANCH, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7,         32'd0,         ERR_ILLEGAL);
        applyStimulus(OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000, 32'h8000_0063, ERR_NONE);
        applyStimulus(OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096,      32'd0,         ERR_RANGE);
        applyStimulus(OP_JAL,    3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'd0,         ERR_RANGE);
        applyStimulus(OP_LUI,    3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'd0,         ERR_ALIGN);
        applyStimulus(OP_CSR,    3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0000_0FFF, 32'hFFF1_10F3, ERR_NONE);
        applyStimulus(OP_CSR,    3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0000_1000, 32'd0,         ERR_RANGE);
        applyStimulus(OP_I_ALU,  3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,         32'h4031_5093, ERR_NONE);
        applyStimulus(OP_I_ALU,  3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 32'd32,        32'd0,         ERR_RANGE);
        applyStimulus(OP_JALR,   3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4,         32'd0,         ERR_ILLEGAL);
        applyStimulus(4'd12,     3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0,         32'd0,         ERR_ILLEGAL);
        drainAll();
        checkOutput("errCodeHeld", {30'b0, err_code}, {30'b0, lastErr});
        checkCounters("errors");

        // Backpressure: two bundles fill the pipeline and the third must wait.
        out_ready = 1'b0;
        applyStimulus(OP_I_ALU, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'd1, 32'h0010_0213, ERR_NONE);
        applyStimulus(OP_I_ALU, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'd2, 32'h0020_0213, ERR_NONE);
        @(negedge clk);
        driveFields(OP_I_ALU, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'd3);
        #1;
        checkOutput("thirdBlocked", {31'b0, in_ready}, 32'd0);
        heldInst = out_inst;
        heldAddr = out_addr;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("stallBlocked", {31'b0, in_ready}, 32'd0);
        checkOutput("holdInst", out_inst, 32'h0010_0213);
        checkOutput("holdAddr", 32'(out_addr), 32'(heldAddr));
        checkOutput("holdStable", out_inst, heldInst);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkOutput("releaseReady", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        pushExpect(32'h0030_0213, ERR_NONE);
        #1;
        in_valid = 1'b0;
        drainAll();
        checkCounters("backpressure");

        // Flush with S1 and S2 both occupied and an output handshake offered in the same cycle.
        out_ready = 1'b0;
        applyStimulus(OP_I_ALU, 3'b000, 1'b0, 5'd6, 5'd0, 5'd0, 32'd6, 32'h0060_0313, ERR_NONE);
        applyStimulus(OP_I_ALU, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd7, 32'h0070_0393, ERR_NONE);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        driveFields(OP_I_ALU, 3'b000, 1'b0, 5'd8, 5'd0, 5'd0, 32'd8);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        instQ.delete();
        errQ.delete();
        expAddr    = AW'(BASE);
        expCount   = '0;
        expWrapped = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("flushOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("flushErrValid", {31'b0, err_valid}, 32'd0);
        checkCounters("flush");
        applyStimulus(OP_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, ERR_NONE);
        drainAll();
        checkCounters("postFlush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
